uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- Serial transmitter that frames a parallel byte into an asynchronous serial line: start bit, LSB-first data, optional parity, stop bit.
- It is the driving end of the single-wire serial link used by the receive-side capture logic in the session designs.
- Upstream logic hands it bytes through a valid/ready handshake.
- The transmitter owns all bit timing from a single clock.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range >= 1.
- DATA_WIDTH, 8, data bits per frame.
- PARITY_EN, 1, 1 = parity bit inserted after data; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.

Ports:
- clk, input, 1, system clock; all state changes on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- tx_valid, input, 1, upstream has a byte on tx_data.
- tx_data, input, DATA_WIDTH, byte to send; sampled only on handshake.
- tx_ready, output, 1, transmitter can accept a byte this cycle.
- tx, output, 1, serial line; idle level 1.
- busy, output, 1, frame in progress, i.e. state is not IDLE.

Behaviour:
- Reset (rst_n = 0, asynchronous, takes effect without a clock edge):
  - state = IDLE, tx = 1, tx_ready = 1, busy = 0.
  - Bit counter, cycle counter and shift register all = 0.
- Reset mid-frame: the frame is aborted immediately and tx returns to 1. The byte is not resumed after reset.
- All outputs are registered; no combinational path from inputs to outputs.
- States and transitions:
  - IDLE: tx = 1, tx_ready = 1. When tx_valid = 1 at a rising edge, latch tx_data into the shift register, compute parity, go to START.
  - START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx = current LSB of the shift register, held CLKS_PER_BIT cycles per bit, LSB first. After DATA_WIDTH bits, go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx = parity bit for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx = 1 for CLKS_PER_BIT cycles, then go to IDLE.
- Parity rule:
  - Even: parity bit = XOR of data bits, so total ones (data + parity) are even.
  - Odd: parity bit = inverted XOR of data bits.
  - Parity is computed from the latched byte, not the live tx_data.
- Handshake:
  - A transfer occurs when tx_valid && tx_ready at a rising edge.
  - tx_ready drops to 0 in the cycle after the handshake and stays 0 until the state is back in IDLE.
  - tx_valid and tx_data changes while busy are ignored; no byte is queued.
- Latency: the start bit appears on tx in the first cycle after the handshake edge.
- Frame length F = (2 + DATA_WIDTH + PARITY_EN) * CLKS_PER_BIT cycles.
- Back-to-back frames with tx_valid held high:
  - Exactly one IDLE cycle (tx = 1, tx_ready = 1) separates frames.
  - Frame period = F + 1 cycles.
- CLKS_PER_BIT = 1: each bit lasts one cycle; the cycle counter never increments past 0.
- Counters:
  - Cycle counter is wide enough for CLKS_PER_BIT - 1 and wraps to 0 at each bit boundary.
  - Bit counter is wide enough for DATA_WIDTH - 1.
  - No overflow states are reachable.
- busy = 1 exactly while state is START, DATA, PARITY or STOP.

Test Plan:
- Defaults, send 0xA5 (even parity):
  - tx sequence per 4-cycle bit is 0, 1,0,1,0,0,1,0,1, parity 0, stop 1.
  - busy high for exactly 44 cycles.
  - tx_ready low from the cycle after the handshake until frame end.
- PARITY_ODD = 1, send 0x01: parity bit = 0. With PARITY_ODD = 0, send 0x01: parity bit = 1.
- PARITY_EN = 0, CLKS_PER_BIT = 1, send 0x3C: frame is 10 cycles, tx = 0,0,0,1,1,1,1,0,0,1.
- tx_valid held high, tx_data = 0x55 then 0xAA:
  - Second start bit begins exactly 45 cycles after the first.
  - Idle gap is one cycle at tx = 1.
  - Second frame carries 0xAA.
- Mid-frame disturbance: toggle tx_data and pulse tx_valid during DATA; transmitted bits remain those of the latched byte.
- Assert rst_n = 0 between clock edges during the DATA state:
  - tx = 1, busy = 0, tx_ready = 1 immediately, with no clock edge.
  - After release, the next handshake sends a clean full frame.

Source files
------------

// File: rtl/uart_tx_frame_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame_if
// Description : Byte handshake between upstream logic and the serial
//               transmitter (valid/ready with parallel data).
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_ready;

  // Upstream side offers bytes.
  modport master (output tx_valid, output tx_data, input tx_ready);
  // Transmitter side accepts bytes.
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame
// Description : Asynchronous serial transmitter. Frames a byte as start bit,
//               LSB-first data, optional parity and stop bit. Every output is
//               registered; all bit timing is derived from clk.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  uart_tx_frame_if.slave up,
  output logic           tx,
  output logic           busy
);

  localparam int CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic             PAR_ON   = (PARITY_EN != 0);
  localparam logic             PAR_INV  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state;
  logic [CYC_W-1:0]      cyc_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  parity_bit;
  logic                  tx_ready_r;
  logic                  bit_end;
  logic [DATA_WIDTH-1:0] shreg_next;

  // Last cycle of the current serial bit; with one clock per bit this is
  // always true because the cycle counter stays at zero.
  assign bit_end    = (cyc_cnt == CYC_LAST);
  assign shreg_next = shreg >> 1;
  assign up.tx_ready = tx_ready_r;

  // Frame sequencer: state, counters and registered line/handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cyc_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      tx_ready_r <= 1'b1;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (up.tx_valid) begin
            // Parity comes from the byte being latched, so later changes
            // on tx_data cannot affect the frame.
            shreg      <= up.tx_data;
            parity_bit <= (^up.tx_data) ^ PAR_INV;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            state      <= S_START;
            tx         <= 1'b0;
            tx_ready_r <= 1'b0;
            busy       <= 1'b1;
          end
        end

        S_START: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            state   <= S_DATA;
            tx      <= shreg[0];
          end else begin
            cyc_cnt <= cyc_cnt + CYC_ONE;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              if (PAR_ON) begin
                state <= S_PARITY;
                tx    <= parity_bit;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              // Shift and present the next bit in the same edge so tx
              // stays registered with no gap between data bits.
              bit_cnt <= bit_cnt + BIT_ONE;
              shreg   <= shreg_next;
              tx      <= shreg_next[0];
            end
          end else begin
            cyc_cnt <= cyc_cnt + CYC_ONE;
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            state   <= S_STOP;
            tx      <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + CYC_ONE;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            cyc_cnt    <= '0;
            state      <= S_IDLE;
            tx         <= 1'b1;
            tx_ready_r <= 1'b1;
            busy       <= 1'b0;
          end else begin
            cyc_cnt <= cyc_cnt + CYC_ONE;
          end
        end

        default: begin
          state      <= S_IDLE;
          cyc_cnt    <= '0;
          bit_cnt    <= '0;
          tx         <= 1'b1;
          tx_ready_r <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_tx_frame
// Description : Self-checking bench for uart_tx_frame. Three instances with
//               different bit timing / parity settings are driven with the
//               same bytes and compared against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;

  localparam int N    = 3;
  localparam int JMAX = 45;

  logic clk = 1'b0;
  logic rst_n;

  int compared   = 0;
  int mismatched = 0;

  logic [N-1:0] tx_v;
  logic [N-1:0] busy_v;
  logic [N-1:0] ready_v;
  logic         s_tx [N][JMAX];

  uart_tx_frame_if #(.DATA_WIDTH(8)) bus0 ();
  uart_tx_frame_if #(.DATA_WIDTH(8)) bus1 ();
  uart_tx_frame_if #(.DATA_WIDTH(8)) bus2 ();

  assign ready_v = {bus2.tx_ready, bus1.tx_ready, bus0.tx_ready};

  // Instance 0: defaults (4 clocks/bit, even parity).
  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0)) u0 (
    .clk(clk), .rst_n(rst_n), .up(bus0), .tx(tx_v[0]), .busy(busy_v[0]));
  // Instance 1: 2 clocks/bit, odd parity.
  uart_tx_frame #(.CLKS_PER_BIT(2), .DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(1)) u1 (
    .clk(clk), .rst_n(rst_n), .up(bus1), .tx(tx_v[1]), .busy(busy_v[1]));
  // Instance 2: 1 clock/bit, no parity.
  uart_tx_frame #(.CLKS_PER_BIT(1), .DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0)) u2 (
    .clk(clk), .rst_n(rst_n), .up(bus2), .tx(tx_v[2]), .busy(busy_v[2]));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- model
  function automatic int cpb_of(int d);
    return (d == 0) ? 4 : (d == 1) ? 2 : 1;
  endfunction

  function automatic int pe_of(int d);
    return (d == 2) ? 0 : 1;
  endfunction

  function automatic int po_of(int d);
    return (d == 1) ? 1 : 0;
  endfunction

  function automatic int flen(int d);
    return (2 + 8 + pe_of(d)) * cpb_of(d);
  endfunction

  // Expected line level j cycles after the handshake edge.
  function automatic logic exp_tx(int d, logic [7:0] data, int j);
    int b;
    if (j >= flen(d)) return 1'b1;
    b = j / cpb_of(d);
    if (b == 0) return 1'b0;
    if (b <= 8) return data[b-1];
    if (pe_of(d) == 1 && b == 9)
      return (($countones(data) % 2) == 1) ^ (po_of(d) == 1);
    return 1'b1;
  endfunction

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    bus0.tx_valid = v; bus0.tx_data = d;
    bus1.tx_valid = v; bus1.tx_data = d;
    bus2.tx_valid = v; bus2.tx_data = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (busy_v == '0 && ready_v == '1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("wait_idle", {31'd0, ok}, 32'd1);
  endtask

  task automatic check_idle(input string tag);
    for (int d = 0; d < N; d++) begin
      chk({tag, "_tx"},    {31'd0, tx_v[d]},    32'd1);
      chk({tag, "_busy"},  {31'd0, busy_v[d]},  32'd0);
      chk({tag, "_ready"}, {31'd0, ready_v[d]}, 32'd1);
    end
  endtask

  // Send one byte to all instances and check every cycle of the frames.
  // With disturb set, tx_data is scrambled and tx_valid pulsed mid-frame.
  task automatic run_frame(input logic [7:0] data, input bit disturb);
    int busy_cnt;
    busy_cnt = 0;
    drive(1'b1, data);
    step();
    drive(1'b0, data);
    for (int j = 0; j < JMAX; j++) begin
      for (int d = 0; d < N; d++) begin
        s_tx[d][j] = tx_v[d];
        chk($sformatf("tx_d%0d_j%0d", d, j), {31'd0, tx_v[d]}, {31'd0, exp_tx(d, data, j)});
        chk($sformatf("busy_d%0d_j%0d", d, j), {31'd0, busy_v[d]}, {31'd0, (j < flen(d))});
        chk($sformatf("ready_d%0d_j%0d", d, j), {31'd0, ready_v[d]}, {31'd0, (j >= flen(d))});
      end
      if (busy_v[0]) busy_cnt++;
      if (disturb) drive((j >= 3 && j <= 5), 8'($urandom));
      step();
    end
    drive(1'b0, data);
    chk("busy_len_d0", busy_cnt, 32'd44);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic [7:0] data;
    logic       par_even;
    logic       par_odd;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [9:0] got;
    logic [7:0] rb;

    tbl[0] = '{8'hA5, 1'b0, 1'b1};
    tbl[1] = '{8'h01, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 1'b0, 1'b1};
    tbl[3] = '{8'h00, 1'b0, 1'b1};
    tbl[4] = '{8'h80, 1'b1, 1'b0};
    tbl[5] = '{8'h3C, 1'b0, 1'b1};

    // Reset state
    rst_n = 1'b0;
    drive(1'b0, 8'h00);
    repeat (3) step();
    check_idle("reset");
    rst_n = 1'b1;
    step();
    check_idle("post_reset");

    // Table-driven frames with hand-computed parity expectations
    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i].data, 1'b0);
      chk($sformatf("parity_even_%02h", tbl[i].data), {31'd0, s_tx[0][36]}, {31'd0, tbl[i].par_even});
      chk($sformatf("parity_odd_%02h", tbl[i].data),  {31'd0, s_tx[1][18]}, {31'd0, tbl[i].par_odd});
    end

    // No parity, one clock per bit, 0x3C: explicit line sequence
    run_frame(8'h3C, 1'b0);
    for (int k = 0; k < 10; k++) got[k] = s_tx[2][k];
    chk("seq_3c_cpb1", {22'd0, got}, {22'd0, 10'b1001111000});

    // Back-to-back with tx_valid held high on the default instance
    drive(1'b1, 8'h55);
    step();
    drive(1'b1, 8'hAA);
    for (int j = 0; j < 2 * JMAX; j++) begin
      if (j < JMAX) begin
        chk($sformatf("b2b_tx_j%0d", j), {31'd0, tx_v[0]}, {31'd0, exp_tx(0, 8'h55, j)});
        chk($sformatf("b2b_ready_j%0d", j), {31'd0, ready_v[0]}, {31'd0, (j >= 44)});
      end else begin
        chk($sformatf("b2b_tx_j%0d", j), {31'd0, tx_v[0]}, {31'd0, exp_tx(0, 8'hAA, j - JMAX)});
        chk($sformatf("b2b_ready_j%0d", j), {31'd0, ready_v[0]}, {31'd0, (j - JMAX >= 44)});
      end
      if (j == 2 * JMAX - 2) drive(1'b0, 8'hAA);
      step();
    end
    drive(1'b0, 8'h00);
    wait_idle();

    // Randomized frames with mid-frame disturbance
    for (int i = 0; i < 16; i++) begin
      run_frame(8'($urandom), 1'b1);
      wait_idle();
    end

    // Asynchronous reset in the middle of the data bits
    rb = 8'($urandom);
    drive(1'b1, rb);
    step();
    drive(1'b0, rb);
    repeat (10) step();
    chk("pre_abort_busy", {31'd0, busy_v[0]}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    #3 rst_n = 1'b1;
    step();
    check_idle("after_release");
    run_frame(8'($urandom), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
